// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, loader state encoding and payload types.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_e;

  // One instruction-memory write: byte address plus word.
  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_wr_t;

  // Byte address of word idx relative to base; wraps modulo 2^32.
  function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] base,
                                                   input logic [CNT_W-1:0]  idx);
    return base + (DATA_W'(idx) << $clog2(WORD_BYTES));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              MemWrite;
  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] write_data;

  // Host side: drives the byte stream, observes memory writes.
  modport master (
    output in_valid, in_data,
    input  in_ready, MemWrite, address, write_data
  );

  // Loader side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, MemWrite, address, write_data
  );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles four accepted bytes into a little-endian 32-bit word.
module word_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_full_c,
  output logic [DATA_W-1:0] word_c
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);
  localparam int unsigned SH_W  = DATA_W - BYTE_W;

  logic [SH_W-1:0]  shift_q;
  logic [IDX_W-1:0] cnt_q;

  // Newest byte enters at the top, so the first byte ends up as the LSB.
  assign word_c      = {byte_i, shift_q};
  assign word_full_c = accept_i && (cnt_q == IDX_W'(WORD_BYTES - 1));

  // Shift register and byte position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept_i) begin
      shift_q <= word_c[DATA_W-1:BYTE_W];
      cnt_q   <= cnt_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: header count, then words streamed into instruction memory
// while the CPU is held in reset.
module imem_loader
  import cpu_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned       MAX_WORDS = 256
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  imem_loader_if.slave bus,
  output logic   cpu_hold,
  output logic   done,
  output logic   error
);

  loader_state_e     state_q, state_d;
  logic [BYTE_W-1:0] hdr_lo_q, hdr_lo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  mem_wr_t           wr_q, wr_d;
  logic              mem_write_q, mem_write_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept_c;
  logic              pk_clear_c;
  logic              pk_accept_c;
  logic              word_full_c;
  logic [DATA_W-1:0] word_c;
  logic [CNT_W-1:0]  hdr_count_c;

  assign accept_c    = bus.in_valid && in_ready_q;
  assign pk_accept_c = accept_c && (state_q == DATA);
  assign hdr_count_c = {bus.in_data, hdr_lo_q};

  word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear_c),
    .accept_i    (pk_accept_c),
    .byte_i      (bus.in_data),
    .word_full_c (word_full_c),
    .word_c      (word_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath next values and registered output levels.
  always_comb begin
    state_d    = state_q;
    hdr_lo_d   = hdr_lo_q;
    count_d    = count_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    pk_clear_c = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = HDR0;
          idx_d      = '0;
          pk_clear_c = 1'b1;
        end
      end
      HDR0: begin
        if (accept_c) begin
          hdr_lo_d = bus.in_data;
          state_d  = HDR1;
        end
      end
      HDR1: begin
        if (accept_c) begin
          count_d = hdr_count_c;
          if (hdr_count_c == '0)                   state_d = DONE;
          else if (32'(hdr_count_c) > MAX_WORDS)   state_d = ERR;
          else                                     state_d = DATA;
        end
      end
      DATA: begin
        if (word_full_c) begin
          wr_d    = '{addr: word_addr(BASE_ADDR, idx_q), data: word_c};
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + CNT_W'(1);
        if ((idx_q + CNT_W'(1)) < count_q) state_d = DATA;
        else                               state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    mem_write_d = (state_d == WRITE);
    in_ready_d  = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
    cpu_hold_d  = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_lo_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      wr_q        <= '{addr: BASE_ADDR, data: '0};
      mem_write_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      hdr_lo_q    <= hdr_lo_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      mem_write_q <= mem_write_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.address    = wr_q.addr;
  assign bus.write_data = wr_q.data;
  assign cpu_hold       = cpu_hold_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: two loaders (base 0 and base 0xFFFFFFFC) share one stimulus stream.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;
  localparam int          BUDGET = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       hold_a, done_a, err_a;
  logic       hold_b, done_b, err_b;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  logic [31:0] exp_a_addr[$], exp_a_data[$], exp_b_addr[$], exp_b_data[$];
  logic [31:0] obs_a_addr[$], obs_a_data[$], obs_b_addr[$], obs_b_data[$];
  logic [31:0] last_a_addr, last_a_data, last_b_addr, last_b_data;

  logic [7:0] p_two[$];
  logic [7:0] p_zero[$];
  logic [7:0] p_big[$];
  logic [7:0] p_alt[$];

  imem_loader_if ifa();
  imem_loader_if ifb();

  assign ifa.in_valid = in_valid;
  assign ifa.in_data  = in_data;
  assign ifb.in_valid = in_valid;
  assign ifb.in_data  = in_data;

  imem_loader #(.BASE_ADDR(BASE_A), .MAX_WORDS(256)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(ifa),
    .cpu_hold(hold_a), .done(done_a), .error(err_a)
  );

  imem_loader #(.BASE_ADDR(BASE_B), .MAX_WORDS(256)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(ifb),
    .cpu_hold(hold_b), .done(done_b), .error(err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected write list derived from the header and payload bytes.
  task automatic plan(input logic [7:0] prog[$]);
    int cnt;
    logic [31:0] w;
    cnt = int'({prog[1], prog[0]});
    if (cnt >= 1 && cnt <= 256) begin
      for (int k = 0; k < cnt; k++) begin
        if (2 + 4 * k + 3 < prog.size()) begin
          w = {prog[2 + 4 * k + 3], prog[2 + 4 * k + 2], prog[2 + 4 * k + 1], prog[2 + 4 * k]};
          exp_a_addr.push_back(BASE_A + 32'(4 * k));
          exp_a_data.push_back(w);
          exp_b_addr.push_back(BASE_B + 32'(4 * k));
          exp_b_data.push_back(w);
        end
      end
    end
  endtask

  // Per-cycle compare of both loaders against the model.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ifa.MemWrite === 1'b1) begin
        if (exp_a_addr.size() == 0) chk("a_unexpected_write", 32'(ifa.MemWrite), 32'd0);
        else begin
          chk("a_addr", ifa.address, exp_a_addr.pop_front());
          chk("a_data", ifa.write_data, exp_a_data.pop_front());
        end
        chk("a_ready_in_write", 32'(ifa.in_ready), 32'd0);
        last_a_addr = ifa.address;
        last_a_data = ifa.write_data;
        obs_a_addr.push_back(ifa.address);
        obs_a_data.push_back(ifa.write_data);
      end else begin
        chk("a_addr_stable", ifa.address, last_a_addr);
        chk("a_data_stable", ifa.write_data, last_a_data);
      end
      chk("a_hold_vs_done", 32'(hold_a), 32'(!done_a));
      if (err_a === 1'b1) chk("a_ready_in_err", 32'(ifa.in_ready), 32'd0);

      if (ifb.MemWrite === 1'b1) begin
        if (exp_b_addr.size() == 0) chk("b_unexpected_write", 32'(ifb.MemWrite), 32'd0);
        else begin
          chk("b_addr", ifb.address, exp_b_addr.pop_front());
          chk("b_data", ifb.write_data, exp_b_data.pop_front());
        end
        chk("b_ready_in_write", 32'(ifb.in_ready), 32'd0);
        last_b_addr = ifb.address;
        last_b_data = ifb.write_data;
        obs_b_addr.push_back(ifb.address);
        obs_b_data.push_back(ifb.write_data);
      end else begin
        chk("b_addr_stable", ifb.address, last_b_addr);
        chk("b_data_stable", ifb.write_data, last_b_data);
      end
      chk("b_hold_vs_done", 32'(hold_b), 32'(!done_b));
    end
  end

  // Start a load and stream bytes; stop_after < size aborts mid-stream.
  task automatic load(input logic [7:0] prog[$], input bit gaps, input int mid_start_at,
                      input int stop_after, output int lat);
    int unsigned s;
    int i, k, guard, w;
    bit v;
    plan(prog);
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    s = cyc;
    i = 0; k = 0; guard = 0;
    while (i < prog.size() && i < stop_after && guard < BUDGET) begin
      @(negedge clk);
      start = (k == mid_start_at);
      k++;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid = v;
      in_data = prog[i];
      if (v && ifa.in_ready === 1'b1) i++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    if (guard >= BUDGET) chk("stream_timeout", 32'(guard), 32'(0));
    if (stop_after >= prog.size()) begin
      w = 0;
      while (!(done_a === 1'b1 || err_a === 1'b1) && w < BUDGET) begin
        @(negedge clk);
        w++;
      end
      if (w >= BUDGET) chk("finish_timeout", 32'(w), 32'(0));
      lat = int'(cyc - (s + 1));
    end
  endtask

  // End-of-load levels and empty model queues.
  task automatic chk_end(input bit exp_done, input bit exp_err);
    chk("a_done", 32'(done_a), 32'(exp_done));
    chk("a_error", 32'(err_a), 32'(exp_err));
    chk("a_hold", 32'(hold_a), 32'(!exp_done));
    chk("a_ready_end", 32'(ifa.in_ready), 32'd0);
    chk("b_done", 32'(done_b), 32'(exp_done));
    chk("b_error", 32'(err_b), 32'(exp_err));
    chk("a_pending", 32'(exp_a_addr.size()), 32'd0);
    chk("b_pending", 32'(exp_b_addr.size()), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_a_ready", 32'(ifa.in_ready), 32'd0);
    chk("rst_a_memwrite", 32'(ifa.MemWrite), 32'd0);
    chk("rst_a_address", ifa.address, 32'h0000_0000);
    chk("rst_a_wdata", ifa.write_data, 32'h0000_0000);
    chk("rst_a_hold", 32'(hold_a), 32'd1);
    chk("rst_a_done", 32'(done_a), 32'd0);
    chk("rst_a_error", 32'(err_a), 32'd0);
    chk("rst_b_address", ifb.address, 32'hFFFF_FFFC);
    chk("rst_b_memwrite", 32'(ifb.MemWrite), 32'd0);
  endtask

  task automatic clear_logs();
    obs_a_addr.delete(); obs_a_data.delete();
    obs_b_addr.delete(); obs_b_data.delete();
  endtask

  initial begin
    int lat;
    p_two  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h15, 8'h00};
    p_zero = '{8'h00, 8'h00};
    p_big  = '{8'h01, 8'h01};
    p_alt  = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    last_a_addr = BASE_A; last_a_data = '0;
    last_b_addr = BASE_B; last_b_data = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals();

    // Two words, no gaps: literal writes and 12-cycle load time.
    clear_logs();
    load(p_two, 1'b0, -1, 1000, lat);
    chk("two_latency", 32'(lat), 32'd12);
    chk_end(1'b1, 1'b0);
    chk("two_nwrites", 32'(obs_a_addr.size()), 32'd2);
    if (obs_a_addr.size() == 2) begin
      chk("two_w0_addr", obs_a_addr[0], 32'h0000_0000);
      chk("two_w0_data", obs_a_data[0], 32'h0000_0513);
      chk("two_w1_addr", obs_a_addr[1], 32'h0000_0004);
      chk("two_w1_data", obs_a_data[1], 32'h0015_0593);
    end
    if (obs_b_addr.size() == 2) begin
      chk("wrap_w0_addr", obs_b_addr[0], 32'hFFFF_FFFC);
      chk("wrap_w1_addr", obs_b_addr[1], 32'h0000_0000);
      chk("wrap_w1_data", obs_b_data[1], 32'h0015_0593);
    end else chk("wrap_nwrites", 32'(obs_b_addr.size()), 32'd2);

    // Count 0: straight to DONE after the header.
    clear_logs();
    load(p_zero, 1'b0, -1, 1000, lat);
    chk("zero_latency", 32'(lat), 32'd2);
    chk_end(1'b1, 1'b0);
    chk("zero_nwrites", 32'(obs_a_addr.size()), 32'd0);

    // Count 257: error, no bytes taken, no writes.
    clear_logs();
    load(p_big, 1'b0, -1, 1000, lat);
    chk("big_latency", 32'(lat), 32'd2);
    chk_end(1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1;
      in_data = 8'hAA;
      @(negedge clk);
      chk("big_ready_held", 32'(ifa.in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("big_nwrites", 32'(obs_a_addr.size()), 32'd0);
    chk("big_error_kept", 32'(err_a), 32'd1);

    // Reload after error.
    clear_logs();
    load(p_two, 1'b0, -1, 1000, lat);
    chk("reload_latency", 32'(lat), 32'd12);
    chk_end(1'b1, 1'b0);

    // Random bubbles plus an ignored mid-load start.
    clear_logs();
    load(p_two, 1'b1, 5, 1000, lat);
    chk_end(1'b1, 1'b0);
    chk("gaps_nwrites", 32'(obs_a_addr.size()), 32'd2);
    if (obs_a_data.size() == 2) chk("gaps_w1_data", obs_a_data[1], 32'h0015_0593);

    // Reset between 2nd and 3rd byte of word 1.
    clear_logs();
    load(p_alt, 1'b0, -1, 8, lat);
    chk("abort_nwrites", 32'(obs_a_addr.size()), 32'd1);
    chk("abort_pending", 32'(exp_a_addr.size()), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    exp_a_addr.delete(); exp_a_data.delete();
    exp_b_addr.delete(); exp_b_data.delete();
    last_a_addr = BASE_A; last_a_data = '0;
    last_b_addr = BASE_B; last_b_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fresh load after reset: starts at the base, no stale bytes.
    clear_logs();
    load(p_alt, 1'b0, -1, 1000, lat);
    chk("fresh_latency", 32'(lat), 32'd12);
    chk_end(1'b1, 1'b0);
    if (obs_a_addr.size() == 2) begin
      chk("fresh_w0_addr", obs_a_addr[0], 32'h0000_0000);
      chk("fresh_w0_data", obs_a_data[0], 32'hDEAD_BEEF);
      chk("fresh_w1_data", obs_a_data[1], 32'hCAFE_F00D);
    end else chk("fresh_nwrites", 32'(obs_a_addr.size()), 32'd2);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
